rv32i_test_host: RTL
====================

RV32I_TEST_HOST -- requirements
Module: rv32i_test_host

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_F000: byte base of the 16-byte register window.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: console FIFO entries; must be a power of two, at least 2.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port i_stb_data, input, 1 bit: data-bus request strobe from the core.
REQ-006 SHALL have port i_wr_en, input, 1 bit: 1 = write, 0 = read.
REQ-007 SHALL have port i_data_addr, input, 32 bits: byte address.
REQ-008 SHALL have port i_data_in, input, 32 bits: write data.
REQ-009 SHALL have port i_wr_mask, input, 4 bits: byte enables.
REQ-010 SHALL have port o_ack_data, output, 1 bit: request-complete pulse.
REQ-011 SHALL have port o_data_out, output, 32 bits: read data, valid while o_ack_data=1.
REQ-012 SHALL have port o_char_valid, output, 1 bit: console byte available.
REQ-013 SHALL have port o_char, output, 8 bits: console byte at the FIFO head.
REQ-014 SHALL have port i_char_ready, input, 1 bit: sink accepts o_char.
REQ-015 SHALL have port o_halt, output, 1 bit: sticky, test finished.
REQ-016 SHALL have port o_pass, output, 1 bit: valid when o_halt=1; 1 = exit code 0.
REQ-017 SHALL have port o_exit_code, output, 31 bits: latched exit code.

Function
REQ-018 SHALL claim a request only when i_stb_data=1 and i_data_addr[31:4]==BASE_ADDR[31:4]; unclaimed requests SHALL produce no ack.
REQ-019 SHALL assert o_ack_data for exactly one cycle, on the cycle after the strobe (latency 1); a strobe held high SHALL be re-serviced each cycle.
REQ-020 SHALL decode offset i_data_addr[3:2] as 0=TOHOST (W), 1=CONSOLE (W), 2=STATUS (R), 3=CYCLE (R); reads of write-only registers SHALL return 0, and writes to read-only registers SHALL be acked and ignored.
REQ-021 SHALL, on a TOHOST write with all four mask bits set and i_data_in[0]=1 while o_halt=0: set o_halt, load o_exit_code=i_data_in[31:1], and set o_pass=(i_data_in[31:1]==0).
REQ-022 SHALL ignore TOHOST writes with data bit0=0, writes with a partial mask, and any write after o_halt=1 (first exit wins).
REQ-023 SHALL, on a CONSOLE write with i_wr_mask[0]=1, push i_data_in[7:0] into the FIFO.
REQ-024 SHALL drop a push while the FIFO is full and set the sticky overflow flag.
REQ-025 SHALL keep o_char_valid = FIFO not empty and o_char = head entry; a pop SHALL occur when o_char_valid and i_char_ready are both 1 on a clock edge.
REQ-026 SHALL, for a simultaneous push and pop, perform both; when the FIFO is full, a simultaneous pop SHALL allow the push without overflow.
REQ-027 SHALL implement the FIFO read and write pointers as wrapping counters with log2(FIFO_DEPTH)+1 bits.
REQ-028 SHALL return STATUS = {16'b0, count[7:0], 5'b0, overflow, o_pass, o_halt}; count saturates its field.
REQ-029 SHALL run a 32-bit cycle counter that increments every cycle while o_halt=0 and freezes at halt; CYCLE reads return its value, and it wraps modulo 2^32.
REQ-030 SHALL, once halted, still service bus reads and keep draining the console.

Reset
REQ-031 SHALL, on i_rst=1 (asynchronous), clear o_ack_data, o_data_out, o_halt, o_pass, o_exit_code, overflow, the cycle counter and both FIFO pointers, so o_char_valid=0 and o_char=0.
REQ-032 SHALL, on reset asserted mid-transaction, suppress the pending ack, and a request presented in the first cycle after release SHALL be serviced normally.

Configuration
REQ-033 SHALL, with TEST_HOST_CONSOLE_EN defined, include the console FIFO and handshake exactly as REQ-023..REQ-027.
REQ-034 SHALL, without TEST_HOST_CONSOLE_EN, contain no FIFO: CONSOLE writes are acked and discarded, o_char_valid=0, o_char=0, and the STATUS count and overflow fields read 0.

Verification
REQ-035 SHALL verify: write TOHOST 32'h0000_0001 -> ack one cycle later; o_halt=1, o_pass=1, o_exit_code=0.
REQ-036 SHALL verify: write TOHOST 32'h0000_0007, then 32'h0000_0001 -> o_exit_code=3, o_pass=0, unchanged by the second write.
REQ-037 SHALL verify: i_char_ready=0 and 9 CONSOLE writes of 'A'..'I' (depth 8) -> STATUS=32'h0000_0804 with overflow=1; then ready=1 -> 'A'..'H' emitted in order, one per cycle.
REQ-038 SHALL verify: FIFO full, simultaneous CONSOLE write 'Z' and pop -> no overflow, and 'Z' is emitted last.
REQ-039 SHALL verify: read CYCLE at cycles 10 and 20 after reset -> difference 10; after halt, two reads return equal values.
REQ-040 SHALL verify: assert i_rst during an acked request with 3 queued chars -> o_ack_data=0, o_char_valid=0, and STATUS reads 0 after release.

Source files
------------

// File: rtl/rv32i_test_host.sv
// Test-harness host peripheral for an RV32I core: TOHOST exit register, console FIFO, STATUS and CYCLE.
// Optional console FIFO is enabled with `define TEST_HOST_CONSOLE_EN.
module rv32i_test_host #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_F000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stb_data,
  input  logic        i_wr_en,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_in,
  input  logic [3:0]  i_wr_mask,
  output logic        o_ack_data,
  output logic [31:0] o_data_out,
  output logic        o_char_valid,
  output logic [7:0]  o_char,
  input  logic        i_char_ready,
  output logic        o_halt,
  output logic        o_pass,
  output logic [30:0] o_exit_code
);

  typedef enum logic [1:0] {
    REG_TOHOST  = 2'd0,
    REG_CONSOLE = 2'd1,
    REG_STATUS  = 2'd2,
    REG_CYCLE   = 2'd3
  } reg_sel_t;

  logic        claim;
  reg_sel_t    sel;
  logic        exit_hit;
  logic [31:0] cycles;
  logic [31:0] rdata;
  logic        overflow;
  logic [7:0]  count_field;

  assign claim    = i_stb_data && (i_data_addr[31:4] == BASE_ADDR[31:4]);
  assign sel      = reg_sel_t'(i_data_addr[3:2]);
  assign exit_hit = claim && i_wr_en && (sel == REG_TOHOST) && (i_wr_mask == 4'hF)
                    && i_data_in[0] && !o_halt;

  always_comb begin
    rdata = '0;
    if (!i_wr_en) begin
      case (sel)
        REG_STATUS: rdata = {16'b0, count_field, 5'b0, overflow, o_pass, o_halt};
        REG_CYCLE:  rdata = cycles;
        default:    rdata = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ack_data  <= 1'b0;
      o_data_out  <= '0;
      o_halt      <= 1'b0;
      o_pass      <= 1'b0;
      o_exit_code <= '0;
      cycles      <= '0;
    end else begin
      o_ack_data <= claim;
      o_data_out <= claim ? rdata : '0;
      if (exit_hit) begin
        o_halt      <= 1'b1;
        o_exit_code <= i_data_in[31:1];
        o_pass      <= (i_data_in[31:1] == 31'd0);
      end
      if (!o_halt) cycles <= cycles + 32'd1;
    end
  end

`ifdef TEST_HOST_CONSOLE_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] fill;
  logic [31:0]   fill32;
  logic          empty;
  logic          full;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          unused;

  assign fill     = wr_ptr - rd_ptr;
  assign fill32   = 32'(fill);
  assign empty    = (fill == '0);
  assign full     = (fill == PW'(FIFO_DEPTH));
  assign pop      = !empty && i_char_ready;
  assign push_req = claim && i_wr_en && (sel == REG_CONSOLE) && i_wr_mask[0];
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign push     = push_req && (!full || pop);

  assign count_field  = (fill32 > 32'd255) ? 8'hFF : fill32[7:0];
  assign o_char_valid = !empty;
  assign o_char       = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  assign unused       = &{1'b0, i_data_addr[1:0]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push_req && !push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= i_data_in[7:0];
  end
`else
  logic unused;

  assign overflow     = 1'b0;
  assign count_field  = 8'h00;
  assign o_char_valid = 1'b0;
  assign o_char       = 8'h00;
  assign unused       = &{1'b0, i_data_addr[1:0], i_char_ready};
`endif

endmodule
